// File: rtl/replay_guard_window_if.sv
// Frame handshake bundle for the replay guard: inbound and outbound
// valid/ready channels plus the replay error pulse and code.
interface replay_guard_window_if #(
    parameter int DATA_W = 8,
    parameter int SEQ_W  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [SEQ_W-1:0]  in_seq;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [SEQ_W-1:0]  out_seq;
    logic [DATA_W-1:0] out_data;
    logic              replay_error;
    logic [1:0]        err_code;

    modport master (
        output in_valid, in_seq, in_data, out_ready,
        input  in_ready, out_valid, out_seq, out_data,
        input  replay_error, err_code
    );

    modport slave (
        input  in_valid, in_seq, in_data, out_ready,
        output in_ready, out_valid, out_seq, out_data,
        output replay_error, err_code
    );
endinterface

// File: rtl/replay_guard_window.sv
// Anti-replay filter: sliding bitmap window over modulo sequence numbers.
// Ports: clk, reset_n (async low), enable, bus (slave: in/out valid-ready
// frames, replay_error, err_code). Macro REPLAY_STATS_EN adds
// drop_dup_cnt / drop_old_cnt saturating drop counters.
module replay_guard_window #(
    parameter int DATA_W = 8,
    parameter int SEQ_W  = 8,
    parameter int WIN    = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    replay_guard_window_if.slave bus
`ifdef REPLAY_STATS_EN
    ,
    output logic [15:0] drop_dup_cnt,
    output logic [15:0] drop_old_cnt
`endif
);
    localparam logic [SEQ_W-1:0] HALF = {1'b1, {(SEQ_W-1){1'b0}}};
    localparam logic [SEQ_W-1:0] WIN_S = SEQ_W'(WIN);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            r_state;
    logic [SEQ_W-1:0]  r_top;
    logic [WIN-1:0]    r_bitmap;
    logic              r_out_valid;
    logic [SEQ_W-1:0]  r_out_seq;
    logic [DATA_W-1:0] r_out_data;
    logic              r_err;
    logic [1:0]        r_code;

    logic              w_take;
    logic [SEQ_W-1:0]  w_ahead;
    logic [SEQ_W-1:0]  w_back;
    logic              w_new;
    logic              w_in_win;
    logic [WIN-1:0]    w_onehot;
    logic              w_seen;
    logic              w_dup;
    logic              w_late;
    logic              w_old;
    logic [WIN-1:0]    w_shift;

    // in_ready is gated by reset_n so it reads 0 while reset is held
    assign bus.in_ready = reset_n && enable
                       && (!r_out_valid || bus.out_ready);
    assign w_take = bus.in_valid && bus.in_ready;

    assign bus.out_valid    = r_out_valid;
    assign bus.out_seq      = r_out_seq;
    assign bus.out_data     = r_out_data;
    assign bus.replay_error = r_err;
    assign bus.err_code     = r_code;

    // Serial-number distances; ahead==HALF falls through to OLD because
    // back is then HALF, which is never below WIN.
    assign w_ahead  = bus.in_seq - r_top;
    assign w_back   = r_top - bus.in_seq;
    assign w_new    = (w_ahead != '0) && (w_ahead < HALF);
    assign w_in_win = (w_back != '0) && (w_back < WIN_S);
    assign w_onehot = w_in_win ? (WIN'(1) << w_back) : '0;
    assign w_seen   = |(r_bitmap & w_onehot);
    assign w_dup    = !w_new && ((w_back == '0) || (w_in_win && w_seen));
    assign w_late   = !w_new && w_in_win && !w_seen;
    assign w_old    = !w_new && !w_dup && !w_late;
    assign w_shift  = (w_ahead >= WIN_S) ? WIN'(1)
                    : ((r_bitmap << w_ahead) | WIN'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_top       <= '0;
            r_bitmap    <= '0;
            r_out_valid <= 1'b0;
            r_out_seq   <= '0;
            r_out_data  <= '0;
            r_err       <= 1'b0;
            r_code      <= 2'b00;
`ifdef REPLAY_STATS_EN
            drop_dup_cnt <= '0;
            drop_old_cnt <= '0;
`endif
        end else begin
            r_err  <= 1'b0;
            r_code <= 2'b00;
            if (r_out_valid && bus.out_ready)
                r_out_valid <= 1'b0;
            if (w_take) begin
                if (r_state == IDLE) begin
                    r_state     <= RUN;
                    r_top       <= bus.in_seq;
                    r_bitmap    <= WIN'(1);
                    r_out_valid <= 1'b1;
                    r_out_seq   <= bus.in_seq;
                    r_out_data  <= bus.in_data;
                end else begin
                    unique case (1'b1)
                        w_new: begin
                            r_top       <= bus.in_seq;
                            r_bitmap    <= w_shift;
                            r_out_valid <= 1'b1;
                            r_out_seq   <= bus.in_seq;
                            r_out_data  <= bus.in_data;
                        end
                        w_late: begin
                            r_bitmap    <= r_bitmap | w_onehot;
                            r_out_valid <= 1'b1;
                            r_out_seq   <= bus.in_seq;
                            r_out_data  <= bus.in_data;
                        end
                        w_dup: begin
                            r_err  <= 1'b1;
                            r_code <= 2'b01;
`ifdef REPLAY_STATS_EN
                            if (drop_dup_cnt != 16'hFFFF)
                                drop_dup_cnt <= drop_dup_cnt + 16'd1;
`endif
                        end
                        w_old: begin
                            r_err  <= 1'b1;
                            r_code <= 2'b10;
`ifdef REPLAY_STATS_EN
                            if (drop_old_cnt != 16'hFFFF)
                                drop_old_cnt <= drop_old_cnt + 16'd1;
`endif
                        end
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_replay_guard_window.sv
// Bench for replay_guard_window: vector table through a scoreboard,
// plus enable, backpressure and reset sequences.
module tb_replay_guard_window;
    localparam logic [1:0] K_FWD = 2'b00;
    localparam logic [1:0] K_DUP = 2'b01;
    localparam logic [1:0] K_OLD = 2'b10;

    typedef struct {
        logic [7:0] seq;
        logic [7:0] data;
        logic [1:0] kind;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic enable = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    vec_t q[$];
    int   exp_dup = 0;
    int   exp_old = 0;

    replay_guard_window_if #(.DATA_W(8), .SEQ_W(8)) bus();

`ifdef REPLAY_STATS_EN
    logic [15:0] drop_dup_cnt;
    logic [15:0] drop_old_cnt;
`endif

    replay_guard_window #(.DATA_W(8), .SEQ_W(8), .WIN(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .bus     (bus.slave)
`ifdef REPLAY_STATS_EN
        ,
        .drop_dup_cnt (drop_dup_cnt),
        .drop_old_cnt (drop_old_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Output monitor: pops one scoreboard entry per output event
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_fwd", {24'd0, bus.out_seq}, 32'hFFFF);
                end else begin
                    vec_t e;
                    e = q.pop_front();
                    check("fwd_kind", 32'(K_FWD), 32'(e.kind));
                    check("out_seq", 32'(bus.out_seq), 32'(e.seq));
                    check("out_data", 32'(bus.out_data), 32'(e.data));
                end
            end
            if (bus.replay_error) begin
                if (q.size() == 0) begin
                    check("unexpected_err", 32'(bus.err_code), 32'hFFFF);
                end else begin
                    vec_t e;
                    e = q.pop_front();
                    check("err_code", 32'(bus.err_code), 32'(e.kind));
                    if (e.kind == K_DUP) exp_dup++;
                    if (e.kind == K_OLD) exp_old++;
`ifdef REPLAY_STATS_EN
                    check("dup_cnt", 32'(drop_dup_cnt), 32'(exp_dup));
                    check("old_cnt", 32'(drop_old_cnt), 32'(exp_old));
`endif
                end
            end
        end
    end

    task automatic send(input logic [7:0] s, input logic [7:0] d,
                        input logic [1:0] k);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_seq   = s;
        bus.in_data  = d;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                q.push_back('{s, d, k});
                @(posedge clk);
                #1;
                bus.in_valid = 1'b0;
                return;
            end
        end
        check("send_timeout", 32'(s), 32'hFFFF);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (q.size() == 0) break;
        end
        @(negedge clk);
        check("drain", 32'(q.size()), 32'd0);
    endtask

    vec_t vt[20];

    initial begin
        vt[0]  = '{8'h05, 8'h48, K_FWD};
        vt[1]  = '{8'h05, 8'h49, K_DUP};
        vt[2]  = '{8'h07, 8'hA7, K_FWD};
        vt[3]  = '{8'h06, 8'hA6, K_FWD};
        vt[4]  = '{8'h06, 8'hA0, K_DUP};
        vt[5]  = '{8'h20, 8'h20, K_FWD};
        vt[6]  = '{8'h10, 8'h10, K_OLD};
        vt[7]  = '{8'h11, 8'hB1, K_FWD};
        vt[8]  = '{8'h11, 8'hB2, K_DUP};
        vt[9]  = '{8'h90, 8'hC0, K_FWD};
        vt[10] = '{8'hFE, 8'hEE, K_FWD};
        vt[11] = '{8'h01, 8'hE1, K_FWD};
        vt[12] = '{8'hFF, 8'hEF, K_FWD};
        vt[13] = '{8'hFE, 8'hE0, K_DUP};
        vt[14] = '{8'h81, 8'h81, K_OLD};
        vt[15] = '{8'h11, 8'h33, K_FWD};
        vt[16] = '{8'h02, 8'h22, K_FWD};
        vt[17] = '{8'h01, 8'h44, K_OLD};
        vt[18] = '{8'h90, 8'h55, K_FWD};
        vt[19] = '{8'h11, 8'h66, K_OLD};

        bus.in_valid  = 1'b0;
        bus.in_seq    = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        enable        = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_seq", 32'(bus.out_seq), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_err", 32'(bus.replay_error), 32'd0);
        check("rst_code", 32'(bus.err_code), 32'd0);
        #2 reset_n = 1'b1;

        for (int i = 0; i < 20; i++)
            send(vt[i].seq, vt[i].data, vt[i].kind);
        drain();

        // enable low: no takes, state retained
        @(posedge clk);
        #1;
        enable       = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_seq   = 8'h91;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("dis_in_ready", 32'(bus.in_ready), 32'd0);
            check("dis_out_valid", 32'(bus.out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        enable       = 1'b1;
        send(8'h90, 8'h01, K_DUP);
        send(8'h91, 8'h91, K_FWD);
        drain();

        // backpressure hold, then pop and take in the same cycle
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        send(8'h92, 8'h5A, K_FWD);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(bus.out_valid), 32'd1);
            check("hold_ready", 32'(bus.in_ready), 32'd0);
            check("hold_data", 32'(bus.out_data), 32'h5A);
            check("hold_seq", 32'(bus.out_seq), 32'h92);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_seq    = 8'h93;
        bus.in_data   = 8'h3C;
        @(negedge clk);
        check("pop_take_ready", 32'(bus.in_ready), 32'd1);
        q.push_back('{8'h93, 8'h3C, K_FWD});
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        drain();

        // reset with a frame in flight
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        send(8'h94, 8'hC4, K_FWD);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        q.delete();
        exp_dup = 0;
        exp_old = 0;
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_seq", 32'(bus.out_seq), 32'd0);
        check("mid_rst_data", 32'(bus.out_data), 32'd0);
        check("mid_rst_err", 32'(bus.replay_error), 32'd0);
        check("mid_rst_code", 32'(bus.err_code), 32'd0);
        check("mid_rst_ready", 32'(bus.in_ready), 32'd0);
`ifdef REPLAY_STATS_EN
        check("mid_rst_dupc", 32'(drop_dup_cnt), 32'd0);
        check("mid_rst_oldc", 32'(drop_old_cnt), 32'd0);
`endif
        bus.out_ready = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        send(8'h94, 8'h11, K_FWD);
        send(8'h94, 8'h12, K_DUP);
        send(8'h95, 8'h13, K_FWD);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
